// File: rtl/decoder_scan.sv
// Registered N-to-2^N decoder (active-low outputs) with direct-select and timed scan modes.
// Optional per-channel mask port and skipping are built when DECODER_SCAN_MASK_EN is defined.
module decoder_scan #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 4,
    localparam int unsigned OUT_N = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e1_n,
    input  logic             e2_n,
    input  logic             e3,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
`ifdef DECODER_SCAN_MASK_EN
    input  logic [OUT_N-1:0] mask,
`endif
    output logic [OUT_N-1:0] y_n,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

    state_e           st_q, st_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [OUT_N-1:0] y_n_q, y_n_d;

    logic             enable;
    logic [OUT_N-1:0] chan_en;
    logic             nxt_found, low_found;
    logic [SEL_W-1:0] nxt_idx, low_idx, cand;

    assign enable = e3 & ~e1_n & ~e2_n;

`ifdef DECODER_SCAN_MASK_EN
    assign chan_en = ~mask;
`else
    assign chan_en = '1;
`endif

    function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] s,
                                                input logic [OUT_N-1:0] en);
        decode = '1;
        if (en[s]) decode[s] = 1'b0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= StIdle;
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            y_n_q  <= '1;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            y_n_q  <= y_n_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        y_n_d     = y_n_q;
        nxt_found = 1'b0;
        nxt_idx   = idx_q;
        low_found = 1'b0;
        low_idx   = '0;
        cand      = '0;

        // Upward search from idx_q; the last candidate is idx_q itself.
        for (int k = 1; k <= int'(OUT_N); k++) begin
            cand = idx_q + SEL_W'(k);
            if (!nxt_found && chan_en[cand]) begin
                nxt_found = 1'b1;
                nxt_idx   = cand;
            end
        end
        for (int i = int'(OUT_N) - 1; i >= 0; i--) begin
            if (chan_en[i]) begin
                low_found = 1'b1;
                low_idx   = SEL_W'(i);
            end
        end

        if (!enable) begin
            st_d  = StIdle;
            idx_d = '0;
            cnt_d = '0;
            y_n_d = '1;
        end else if (!mode) begin
            st_d  = StDirect;
            idx_d = sel;
            cnt_d = '0;
            y_n_d = decode(sel, chan_en);
        end else begin
            st_d = StScan;
            if (st_q != StScan) begin
                cnt_d = '0;
                idx_d = low_idx;
                y_n_d = low_found ? decode(low_idx, chan_en) : '1;
            end else if (cnt_q == 16'(DWELL - 1)) begin
                cnt_d = '0;
                if (nxt_found) begin
                    idx_d  = nxt_idx;
                    wrap_d = (nxt_idx <= idx_q);
                    y_n_d  = decode(nxt_idx, chan_en);
                end else begin
                    y_n_d = '1;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign y_n  = y_n_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (SEL_W=3, DWELL=4).
// Mask scenarios are included when DECODER_SCAN_MASK_EN is defined.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       e1_n, e2_n, e3, mode;
    logic [2:0] sel;
    logic [7:0] y_n;
    logic [2:0] idx;
    logic       wrap;
`ifdef DECODER_SCAN_MASK_EN
    logic [7:0] mask;
`endif

    int n_vec = 0;
    int n_err = 0;

    decoder_scan #(.SEL_W(3), .DWELL(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .e1_n (e1_n),
        .e2_n (e2_n),
        .e3   (e3),
        .mode (mode),
        .sel  (sel),
`ifdef DECODER_SCAN_MASK_EN
        .mask (mask),
`endif
        .y_n  (y_n),
        .idx  (idx),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                           input logic ew);
        chk({tag, ".y_n"}, 32'(y_n), 32'(ey));
        chk({tag, ".idx"}, 32'(idx), 32'(ei));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    initial begin
        logic [7:0] ey;
        logic [2:0] ei;
        logic       ew;

        rst = 1'b1; e1_n = 1'b1; e2_n = 1'b1; e3 = 1'b0; mode = 1'b0; sel = 3'd0;
`ifdef DECODER_SCAN_MASK_EN
        mask = 8'h00;
`endif
        #1;
        chk_out("reset", 8'hFF, 3'd0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Direct decode of sel=5, then drop enable.
        e1_n = 1'b0; e2_n = 1'b0; e3 = 1'b1; mode = 1'b0; sel = 3'd5;
        step();
        chk_out("direct5", 8'b1101_1111, 3'd5, 1'b0);
        e2_n = 1'b1;
        step();
        chk_out("disable", 8'hFF, 3'd0, 1'b0);

        // Every sel against every enable combination.
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 8; c++) begin
                sel = 3'(s);
                {e3, e1_n, e2_n} = 3'(c);
                step();
                if (c == 4) begin
                    ey = ~(8'd1 << s);
                    ei = 3'(s);
                end else begin
                    ey = 8'hFF;
                    ei = 3'd0;
                end
                chk_out("sweep", ey, ei, 1'b0);
            end
        end

        // Scan from direct: 0..7,0 with 4-cycle dwell, wrap once per 32 cycles.
        e1_n = 1'b0; e2_n = 1'b0; e3 = 1'b1; mode = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            ei = 3'((c / 4) % 8);
            ew = (c == 32);
            chk_out("scan", ~(8'd1 << ei), ei, ew);
            chk("scan.onehot", 32'($countones(~y_n)), 32'd1);
        end

        // Restart scan, reach idx=3, then pulse reset mid-dwell.
        mode = 1'b0;
        step();
        mode = 1'b1;
        for (int c = 0; c < 13; c++) step();
        chk_out("pre_rst", 8'b1111_0111, 3'd3, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 8'hFF, 3'd0, 1'b0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            ei = (c < 4) ? 3'd0 : 3'd1;
            chk_out("post_rst", ~(8'd1 << ei), ei, 1'b0);
        end

        // Mid-scan switch to direct sel=6, then back to scan.
        mode = 1'b0; sel = 3'd6;
        step();
        chk_out("to_direct", 8'b1011_1111, 3'd6, 1'b0);
        mode = 1'b1;
        step();
        chk_out("to_scan", 8'b1111_1110, 3'd0, 1'b0);

`ifdef DECODER_SCAN_MASK_EN
        mode = 1'b0;
        step();
        mask = 8'b0101_0101; mode = 1'b1;
        for (int c = 0; c < 17; c++) begin
            step();
            ei = 3'(((c / 4) % 4) * 2 + 1);
            ew = (c == 16);
            chk_out("mscan", ~(8'd1 << ei), ei, ew);
        end
        mask = 8'hFF;
        for (int c = 0; c < 8; c++) step();
        chk_out("mall", 8'hFF, 3'd1, 1'b0);
        mode = 1'b0; sel = 3'd0;
        step();
        chk_out("mdirect", 8'hFF, 3'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
